// File: rtl/bubble_sort_unit.sv
// rtl/bubble_sort_unit.sv - nine-entry sequential bubble sort, one compare-exchange per clock
module bubble_sort_unit #(
  parameter int BITWIDTH = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start_i,
  input  logic [BITWIDTH-1:0] in_data0_i,
  input  logic [BITWIDTH-1:0] in_data1_i,
  input  logic [BITWIDTH-1:0] in_data2_i,
  input  logic [BITWIDTH-1:0] in_data3_i,
  input  logic [BITWIDTH-1:0] in_data4_i,
  input  logic [BITWIDTH-1:0] in_data5_i,
  input  logic [BITWIDTH-1:0] in_data6_i,
  input  logic [BITWIDTH-1:0] in_data7_i,
  input  logic [BITWIDTH-1:0] in_data8_i,
  output logic [BITWIDTH-1:0] out_data0_o,
  output logic [BITWIDTH-1:0] out_data1_o,
  output logic [BITWIDTH-1:0] out_data2_o,
  output logic [BITWIDTH-1:0] out_data3_o,
  output logic [BITWIDTH-1:0] out_data4_o,
  output logic [BITWIDTH-1:0] out_data5_o,
  output logic [BITWIDTH-1:0] out_data6_o,
  output logic [BITWIDTH-1:0] out_data7_o,
  output logic [BITWIDTH-1:0] out_data8_o,
  output logic                valid_o
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t              state;
  logic [BITWIDTH-1:0] a    [9];
  logic [BITWIDTH-1:0] in_w [9];
  logic [2:0]          p;
  logic [3:0]          j;
  logic [3:0]          j1;
  logic [3:0]          j_last;

  assign in_w[0] = in_data0_i;
  assign in_w[1] = in_data1_i;
  assign in_w[2] = in_data2_i;
  assign in_w[3] = in_data3_i;
  assign in_w[4] = in_data4_i;
  assign in_w[5] = in_data5_i;
  assign in_w[6] = in_data6_i;
  assign in_w[7] = in_data7_i;
  assign in_w[8] = in_data8_i;

  assign out_data0_o = a[0];
  assign out_data1_o = a[1];
  assign out_data2_o = a[2];
  assign out_data3_o = a[3];
  assign out_data4_o = a[4];
  assign out_data5_o = a[5];
  assign out_data6_o = a[6];
  assign out_data7_o = a[7];
  assign out_data8_o = a[8];

  assign j1     = j + 4'd1;
  // Last compare index of the current pass; each pass is one pair shorter.
  assign j_last = {1'b0, 3'd7 - p};

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 9; k++) a[k] <= '0;
      valid_o <= 1'b0;
      p       <= '0;
      j       <= '0;
      state   <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            for (int k = 0; k < 9; k++) a[k] <= in_w[k];
            valid_o <= 1'b0;
            p       <= '0;
            j       <= '0;
            state   <= SORT;
          end
        end
        SORT: begin
          if (a[j] > a[j1]) begin
            a[j]  <= a[j1];
            a[j1] <= a[j];
          end
          if (j < j_last) begin
            j <= j + 4'd1;
          end else if (p < 3'd7) begin
            p <= p + 3'd1;
            j <= '0;
          end else begin
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_unit.sv
// tb/tb_bubble_sort_unit.sv - directed-vector bench for bubble_sort_unit
module tb_bubble_sort_unit;

  logic        CLK;
  logic        RST;
  logic        start_i;
  logic [15:0] din  [9];
  logic [15:0] dout [9];
  logic        valid_o;

  logic [15:0] vin  [9];
  logic [15:0] vexp [9];
  int          errors;
  int          checks;

  bubble_sort_unit #(.BITWIDTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (start_i),
    .in_data0_i (din[0]),
    .in_data1_i (din[1]),
    .in_data2_i (din[2]),
    .in_data3_i (din[3]),
    .in_data4_i (din[4]),
    .in_data5_i (din[5]),
    .in_data6_i (din[6]),
    .in_data7_i (din[7]),
    .in_data8_i (din[8]),
    .out_data0_o(dout[0]),
    .out_data1_o(dout[1]),
    .out_data2_o(dout[2]),
    .out_data3_o(dout[3]),
    .out_data4_o(dout[4]),
    .out_data5_o(dout[5]),
    .out_data6_o(dout[6]),
    .out_data7_o(dout[7]),
    .out_data8_o(dout[8]),
    .valid_o    (valid_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s_out%0d", tag, k), {16'h0, dout[k]}, {16'h0, vexp[k]});
  endtask

  // Loads vin, pulses start, and checks the exact 36-cycle latency and result.
  // With disturb set, inputs change and start is pulsed again mid-sort.
  task automatic run_sort(input string tag, input bit disturb);
    for (int k = 0; k < 9; k++) din[k] = vin[k];
    start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    check({tag, "_valid_drop"}, {31'h0, valid_o}, 32'h0);
    for (int c = 1; c <= 36; c++) begin
      @(posedge CLK); #1;
      if (disturb && c == 5)
        for (int k = 0; k < 9; k++) din[k] = 16'h1234 + 16'(k);
      if (disturb && c == 10) start_i = 1'b1;
      if (disturb && c == 11) start_i = 1'b0;
      if (c == 35) check({tag, "_valid_early"}, {31'h0, valid_o}, 32'h0);
    end
    check({tag, "_valid_rise"}, {31'h0, valid_o}, 32'h1);
    check_outputs(tag);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    RST     = 1'b1;
    start_i = 1'b0;
    for (int k = 0; k < 9; k++) din[k] = 16'h00AA + 16'(k);

    for (int c = 0; c < 3; c++) begin
      start_i = ~start_i;
      @(posedge CLK); #1;
    end
    start_i = 1'b0;
    for (int k = 0; k < 9; k++) vexp[k] = 16'h0;
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check_outputs("rst");
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_valid", {31'h0, valid_o}, 32'h0);
    check("idle_out4", {16'h0, dout[4]}, 32'h0);

    vin  = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd4, 16'd6, 16'd8, 16'd2, 16'd5};
    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    run_sort("basic", 1'b0);
    check("basic_median", {16'h0, dout[4]}, 32'd5);

    repeat (4) @(posedge CLK);
    #1;
    check("hold_valid", {31'h0, valid_o}, 32'h1);
    check("hold_out8", {16'h0, dout[8]}, 32'd9);

    vin  = '{16'hFFFF, 16'd0, 16'd5, 16'd5, 16'd0, 16'hFFFF, 16'd7, 16'd5, 16'd1};
    vexp = '{16'd0, 16'd0, 16'd1, 16'd5, 16'd5, 16'd5, 16'd7, 16'hFFFF, 16'hFFFF};
    run_sort("dup", 1'b0);

    vin  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    run_sort("presorted", 1'b0);

    vin  = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    run_sort("reverse", 1'b0);

    vin  = '{16'd40, 16'd10, 16'd30, 16'd20, 16'd90, 16'd60, 16'd50, 16'd80, 16'd70};
    vexp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90};
    run_sort("disturb", 1'b1);

    vin  = '{16'd8, 16'd8, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd8};
    run_sort("restart", 1'b0);

    vin = '{16'd9, 16'd3, 16'd7, 16'd1, 16'd4, 16'd6, 16'd8, 16'd2, 16'd5};
    for (int k = 0; k < 9; k++) din[k] = vin[k];
    start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 9; k++) vexp[k] = 16'h0;
    check("midrst_valid", {31'h0, valid_o}, 32'h0);
    check_outputs("midrst");
    repeat (40) @(posedge CLK);
    #1;
    check("midrst_idle_valid", {31'h0, valid_o}, 32'h0);
    check("midrst_idle_out0", {16'h0, dout[0]}, 32'h0);

    vexp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    run_sort("after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
